// File: rtl/cpu_pkg.sv
// Shared CPU datapath widths and the GRF write request record.
package cpu_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned DATA_W     = 32;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [DATA_W-1:0]     data;
      logic [DATA_W-1:0]     pc;
   } wr_req_t;

endpackage

// File: rtl/grf_wr_fifo.sv
// Circular buffer of pending long-latency GRF writes with per-entry live bits.
// A kill-by-address input retires stale entries that a younger writeback has
// overtaken; the incoming push is never killed (it is the youngest write).
module grf_wr_fifo
   import cpu_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 push,
   input  wr_req_t                              push_req,
   input  logic                                 pop,
   input  logic                                 kill_en,
   input  logic [REG_ADDR_W-1:0]                kill_addr,
   output logic                                 full,
   output logic                                 empty,
   output logic                                 head_live,
   output wr_req_t                              head_req,
   output logic [DEPTH-1:0]                     live,
   output logic [DEPTH-1:0][REG_ADDR_W-1:0]     ent_addr
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   wr_req_t           mem [DEPTH];
   logic [DEPTH-1:0]  live_q;
   logic [DEPTH-1:0]  live_nxt;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [CNT_W-1:0]  count;
   logic              do_pop;

   assign empty    = (count == '0);
   assign full     = (count == CNT_W'(DEPTH));
   assign do_pop   = pop && !empty;
   assign head_live = !empty && live_q[rd_ptr];
   assign head_req = mem[rd_ptr];
   assign live     = live_q;

   // Expose stored destination addresses for pending-write lookups.
   always_comb begin
      ent_addr = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         ent_addr[i] = mem[i].addr;
      end
   end

   // Next live bits: kill matching stored entries, clear the popped slot,
   // then mark the pushed slot live (push last so the younger B write wins).
   always_comb begin
      live_nxt = live_q;
      if (kill_en) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (mem[i].addr == kill_addr) begin
               live_nxt[i] = 1'b0;
            end
         end
      end
      if (do_pop) begin
         live_nxt[rd_ptr] = 1'b0;
      end
      if (push) begin
         live_nxt[wr_ptr] = 1'b1;
      end
   end

   // Pointer, count and live-bit state.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         live_q <= '0;
      end else begin
         live_q <= live_nxt;
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         case ({push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Entry payload storage; validity is tracked by count and live bits.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_req;
      end
   end

endmodule

// File: rtl/grf_wr_arbiter.sv
// Arbitrates the single GRF write port between writeback (A, never stalled)
// and the long-latency unit (B, valid/ready into a small FIFO). Also provides
// a starvation bubble request and pending-write lookups for the stall logic.
module grf_wr_arbiter
   import cpu_pkg::*;
#(
   parameter int unsigned DEPTH        = 2,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  a_we,
   input  logic [REG_ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0]     a_data,
   input  logic [DATA_W-1:0]     a_pc,
   input  logic                  b_valid,
   output logic                  b_ready,
   input  logic [REG_ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0]     b_data,
   input  logic [DATA_W-1:0]     b_pc,
   output logic                  grf_we,
   output logic [REG_ADDR_W-1:0] grf_addr,
   output logic [DATA_W-1:0]     grf_wdata,
   output logic [DATA_W-1:0]     grf_pc,
   output logic                  starve_stall,
   input  logic [REG_ADDR_W-1:0] rs_q,
   input  logic [REG_ADDR_W-1:0] rt_q,
   output logic                  rs_pend,
   output logic                  rt_pend
);

   localparam int unsigned SC_W = $clog2(STARVE_LIMIT + 1);

   logic                              a_act;
   logic                              b_fire;
   logic                              push;
   logic                              head_pop;
   logic                              full;
   logic                              empty;
   logic                              head_live;
   wr_req_t                           head_req;
   wr_req_t                           push_req;
   logic [DEPTH-1:0]                  live;
   logic [DEPTH-1:0][REG_ADDR_W-1:0]  ent_addr;
   logic [SC_W-1:0]                   starve_cnt;

   // Writes to $0 never count as a write, so they neither own the port nor kill.
   assign a_act    = a_we && (a_addr != '0);
   // A dead head always retires; a live head retires only when A is idle.
   assign head_pop = !empty && (!head_live || !a_act);
   assign b_ready  = !full || head_pop;
   assign b_fire   = b_valid && b_ready;
   assign push     = b_fire && (b_addr != '0);
   assign push_req = '{addr: b_addr, data: b_data, pc: b_pc};

   grf_wr_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_req  (push_req),
      .pop       (head_pop),
      .kill_en   (a_act),
      .kill_addr (a_addr),
      .full      (full),
      .empty     (empty),
      .head_live (head_live),
      .head_req  (head_req),
      .live      (live),
      .ent_addr  (ent_addr)
   );

   // Port ownership mux: A first, then a live FIFO head; nothing during reset.
   always_comb begin
      grf_we    = 1'b0;
      grf_addr  = '0;
      grf_wdata = '0;
      grf_pc    = '0;
      if (!reset) begin
         if (a_act) begin
            grf_we    = 1'b1;
            grf_addr  = a_addr;
            grf_wdata = a_data;
            grf_pc    = a_pc;
         end else if (head_live) begin
            grf_we    = 1'b1;
            grf_addr  = head_req.addr;
            grf_wdata = head_req.data;
            grf_pc    = head_req.pc;
         end
      end
   end

   // Starvation counter: counts cycles a live head loses to A, saturating.
   always_ff @(posedge clk) begin
      if (reset || empty || head_pop) begin
         starve_cnt <= '0;
      end else if (head_live && a_act && (starve_cnt < SC_W'(STARVE_LIMIT))) begin
         starve_cnt <= starve_cnt + SC_W'(1);
      end
   end

   assign starve_stall = (starve_cnt >= SC_W'(STARVE_LIMIT));

   // Pending-write lookups over live entries plus a same-cycle B transfer.
   always_comb begin
      logic rs_hit;
      logic rt_hit;
      rs_hit = b_fire && (b_addr == rs_q);
      rt_hit = b_fire && (b_addr == rt_q);
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (live[i] && (ent_addr[i] == rs_q)) rs_hit = 1'b1;
         if (live[i] && (ent_addr[i] == rt_q)) rt_hit = 1'b1;
      end
      rs_pend = rs_hit && (rs_q != '0);
      rt_pend = rt_hit && (rt_q != '0);
   end

endmodule

// File: tb/tb_grf_wr_arbiter.sv
// Directed test of grf_wr_arbiter (DEPTH=2, STARVE_LIMIT=4).
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_grf_wr_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        a_we;
   logic [4:0]  a_addr;
   logic [31:0] a_data;
   logic [31:0] a_pc;
   logic        b_valid;
   logic        b_ready;
   logic [4:0]  b_addr;
   logic [31:0] b_data;
   logic [31:0] b_pc;
   logic        grf_we;
   logic [4:0]  grf_addr;
   logic [31:0] grf_wdata;
   logic [31:0] grf_pc;
   logic        starve_stall;
   logic [4:0]  rs_q;
   logic [4:0]  rt_q;
   logic        rs_pend;
   logic        rt_pend;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   grf_wr_arbiter #(
      .DEPTH        (2),
      .STARVE_LIMIT (4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .a_we         (a_we),
      .a_addr       (a_addr),
      .a_data       (a_data),
      .a_pc         (a_pc),
      .b_valid      (b_valid),
      .b_ready      (b_ready),
      .b_addr       (b_addr),
      .b_data       (b_data),
      .b_pc         (b_pc),
      .grf_we       (grf_we),
      .grf_addr     (grf_addr),
      .grf_wdata    (grf_wdata),
      .grf_pc       (grf_pc),
      .starve_stall (starve_stall),
      .rs_q         (rs_q),
      .rt_q         (rt_q),
      .rs_pend      (rs_pend),
      .rt_pend      (rt_pend)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // One cycle: wait for the falling edge, apply inputs, let logic settle.
   task automatic step(input logic aw, input logic [4:0] aa, input logic [31:0] ad,
                       input logic bv, input logic [4:0] ba, input logic [31:0] bd);
      @(negedge clk);
      a_we    = aw;
      a_addr  = aa;
      a_data  = ad;
      a_pc    = 32'h0040_0000 | ad;
      b_valid = bv;
      b_addr  = ba;
      b_data  = bd;
      b_pc    = 32'h0080_0000 | bd;
      #1;
   endtask

   initial begin
      reset = 1'b1;
      a_we = 1'b0; a_addr = '0; a_data = '0; a_pc = '0;
      b_valid = 1'b0; b_addr = '0; b_data = '0; b_pc = '0;
      rs_q = 5'd5; rt_q = 5'd7;
      repeat (2) @(negedge clk);

      // Reset state
      reset = 1'b0;
      step(0, 0, 0, 0, 0, 0);
      check("rst_b_ready", 32'(b_ready), 1);
      check("rst_grf_we", 32'(grf_we), 0);
      check("rst_starve", 32'(starve_stall), 0);
      check("rst_rs_pend", 32'(rs_pend), 0);
      check("rst_rt_pend", 32'(rt_pend), 0);

      // B only: transfer, then write one cycle later
      step(0, 0, 0, 1, 5'd5, 32'h11);
      check("bonly_ready", 32'(b_ready), 1);
      check("bonly_pend_xfer", 32'(rs_pend), 1);
      check("bonly_we_xfer", 32'(grf_we), 0);
      step(0, 0, 0, 0, 0, 0);
      check("bonly_we", 32'(grf_we), 1);
      check("bonly_addr", 32'(grf_addr), 5);
      check("bonly_data", grf_wdata, 32'h11);
      check("bonly_pc", grf_pc, 32'h0080_0011);
      check("bonly_pend_q", 32'(rs_pend), 1);
      step(0, 0, 0, 0, 0, 0);
      check("bonly_empty_we", 32'(grf_we), 0);
      check("bonly_empty_pend", 32'(rs_pend), 0);

      // Contention: A writes $3 for six cycles, B queues $7 in the first.
      // Counter reaches 4 after four blocked cycles; stall shows on the fifth.
      rs_q = 5'd7;
      step(1, 5'd3, 32'h33, 1, 5'd7, 32'h77);
      check("cont0_addr", 32'(grf_addr), 3);
      check("cont0_starve", 32'(starve_stall), 0);
      for (int i = 1; i <= 5; i++) begin
         step(1, 5'd3, 32'h33, 0, 0, 0);
         check("cont_addr", 32'(grf_addr), 3);
         check("cont_data", grf_wdata, 32'h33);
         check("cont_starve", 32'(starve_stall), (i == 5) ? 1 : 0);
         check("cont_pend", 32'(rs_pend), 1);
      end
      step(0, 0, 0, 0, 0, 0);
      check("cont_drain_we", 32'(grf_we), 1);
      check("cont_drain_addr", 32'(grf_addr), 7);
      check("cont_drain_data", grf_wdata, 32'h77);
      check("cont_drain_starve", 32'(starve_stall), 1);
      step(0, 0, 0, 0, 0, 0);
      check("cont_after_we", 32'(grf_we), 0);
      check("cont_after_starve", 32'(starve_stall), 0);

      // Full / backpressure with A busy
      step(1, 5'd3, 32'h33, 1, 5'd10, 32'hA0);
      check("full_r0", 32'(b_ready), 1);
      step(1, 5'd3, 32'h33, 1, 5'd11, 32'hA1);
      check("full_r1", 32'(b_ready), 1);
      step(1, 5'd3, 32'h33, 1, 5'd12, 32'hA2);
      check("full_r2", 32'(b_ready), 0);
      step(1, 5'd3, 32'h33, 1, 5'd12, 32'hA2);
      check("full_r2_hold", 32'(b_ready), 0);
      step(0, 0, 0, 1, 5'd12, 32'hA2);
      check("full_pop_ready", 32'(b_ready), 1);
      check("full_pop_addr", 32'(grf_addr), 10);
      check("full_pop_data", grf_wdata, 32'hA0);
      step(0, 0, 0, 0, 0, 0);
      check("full_d1_addr", 32'(grf_addr), 11);
      check("full_d1_data", grf_wdata, 32'hA1);
      step(0, 0, 0, 0, 0, 0);
      check("full_d2_addr", 32'(grf_addr), 12);
      check("full_d2_data", grf_wdata, 32'hA2);
      step(0, 0, 0, 0, 0, 0);
      check("full_done_we", 32'(grf_we), 0);

      // Kill: B queues $9=AA, then A writes $9=BB
      rs_q = 5'd9;
      step(1, 5'd3, 32'h33, 1, 5'd9, 32'hAA);
      step(1, 5'd9, 32'hBB, 0, 0, 0);
      check("kill_a_addr", 32'(grf_addr), 9);
      check("kill_a_data", grf_wdata, 32'hBB);
      check("kill_pend_before", 32'(rs_pend), 1);
      step(0, 0, 0, 0, 0, 0);
      check("kill_dead_we", 32'(grf_we), 0);
      check("kill_pend_after", 32'(rs_pend), 0);
      step(0, 0, 0, 0, 0, 0);
      check("kill_empty_we", 32'(grf_we), 0);

      // Same-cycle A and B to $9: B is younger and survives
      step(1, 5'd9, 32'hC0, 1, 5'd9, 32'hC1);
      check("same_pend", 32'(rs_pend), 1);
      step(0, 0, 0, 0, 0, 0);
      check("same_we", 32'(grf_we), 1);
      check("same_data", grf_wdata, 32'hC1);
      step(0, 0, 0, 0, 0, 0);

      // $0 handling
      rs_q = 5'd0;
      step(1, 5'd3, 32'h33, 1, 5'd6, 32'h66);
      step(1, 5'd0, 32'hFF, 0, 0, 0);
      check("zero_a_we", 32'(grf_we), 1);
      check("zero_a_addr", 32'(grf_addr), 6);
      check("zero_a_data", grf_wdata, 32'h66);
      step(0, 0, 0, 0, 0, 0);
      check("zero_a_after", 32'(grf_we), 0);
      step(0, 0, 0, 1, 5'd0, 32'h99);
      check("zero_b_ready", 32'(b_ready), 1);
      check("zero_b_we", 32'(grf_we), 0);
      check("zero_b_pend", 32'(rs_pend), 0);
      step(0, 0, 0, 0, 0, 0);
      check("zero_b_after", 32'(grf_we), 0);

      // Reset with two queued entries
      rs_q = 5'd20; rt_q = 5'd21;
      step(1, 5'd3, 32'h33, 1, 5'd20, 32'h20);
      step(1, 5'd3, 32'h33, 1, 5'd21, 32'h21);
      check("rq_pend_rs", 32'(rs_pend), 1);
      @(negedge clk);
      reset = 1'b1;
      a_we = 1'b0; b_valid = 1'b0;
      #1;
      check("rq_during_we", 32'(grf_we), 0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("rq_after_we", 32'(grf_we), 0);
      check("rq_after_ready", 32'(b_ready), 1);
      check("rq_after_rs", 32'(rs_pend), 0);
      check("rq_after_rt", 32'(rt_pend), 0);
      step(0, 0, 0, 0, 0, 0);
      check("rq_later_we", 32'(grf_we), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
